// File: rtl/system_unit.sv
// Purpose: execute-stage system unit; 64-bit cycle/time/instret counters, counter reads, SCALL/SBREAK trap request.
// Latency: counter reads return o_result/o_result_valid one cycle after acceptance; traps raise o_trap one cycle later.
// Backpressure: o_busy while a trap is pending; requests under i_stall or o_busy are not sampled and must be re-presented.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid, i_stall     request present / execute stalled
//   i_sysop              operation (t_sysop)
//   i_retire             one instruction retired this cycle
//   i_trap_ack           trap taken by fetch/hazard logic
//   o_result(_valid)     counter read data and its one-cycle strobe
//   o_trap, o_trap_cause trap request level (held to ack), 0 = SCALL / 1 = SBREAK
//   o_busy               unit cannot accept a request
// Optional: define SYSTEM_UNIT_INSTRET_EN to build the instret counter; otherwise
// RDINSTRET[H] read as 0 and i_retire is ignored.

package system_unit_pkg;
  typedef enum logic [3:0] {
    SYSOP_RDCYCLE    = 4'd0,
    SYSOP_RDCYCLEH   = 4'd1,
    SYSOP_RDTIME     = 4'd2,
    SYSOP_RDTIMEH    = 4'd3,
    SYSOP_RDINSTRET  = 4'd4,
    SYSOP_RDINSTRETH = 4'd5,
    SYSOP_SCALL      = 4'd6,
    SYSOP_SBREAK     = 4'd7
  } t_sysop;
endpackage

module system_unit
  import system_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CNT_W    = 64,
  parameter int TIME_DIV = 50
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_stall,
  input  t_sysop          i_sysop,
  input  logic            i_retire,
  input  logic            i_trap_ack,
  output logic [XLEN-1:0] o_result,
  output logic            o_result_valid,
  output logic            o_trap,
  output logic            o_trap_cause,
  output logic            o_busy
);

  localparam int PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TIME_DIV - 1);

  typedef enum logic {ST_IDLE, ST_TRAP_PEND} t_state;

  t_state            r_state;
  t_state            w_state_nxt;
  logic [CNT_W-1:0]  r_cycle;
  logic [CNT_W-1:0]  r_time;
  logic [PW-1:0]     r_presc;
  logic [CNT_W-1:0]  w_instret;
  logic [XLEN-1:0]   r_result;
  logic              r_result_vld;
  logic              r_cause;

  logic              w_accept;
  logic              w_is_trap;
  logic              w_presc_wrap;
  logic [CNT_W-1:0]  w_sel_cnt;
  logic              w_sel_hi;
  logic [XLEN-1:0]   w_rd_data;

  assign w_accept     = i_valid && !i_stall && (r_state == ST_IDLE);
  assign w_is_trap    = (i_sysop == SYSOP_SCALL) || (i_sysop == SYSOP_SBREAK);
  assign w_presc_wrap = (r_presc == PRESC_LAST);

  // Free-running counters: they never look at state or stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle <= '0;
      r_time  <= '0;
      r_presc <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_W'(1);
      if (w_presc_wrap) begin
        r_presc <= '0;
        r_time  <= r_time + CNT_W'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

`ifdef SYSTEM_UNIT_INSTRET_EN
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instret <= '0;
    end else if (i_retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign w_instret = r_instret;
`else
  logic w_unused_retire;
  assign w_unused_retire = i_retire;
  assign w_instret       = '0;
`endif

  // Counter/half select; unlisted opcodes fall through to the RDCYCLE default.
  always_comb begin
    w_sel_cnt = r_cycle;
    w_sel_hi  = 1'b0;
    case (i_sysop)
      SYSOP_RDCYCLEH:   w_sel_hi = 1'b1;
      SYSOP_RDTIME:     w_sel_cnt = r_time;
      SYSOP_RDTIMEH: begin
        w_sel_cnt = r_time;
        w_sel_hi  = 1'b1;
      end
      SYSOP_RDINSTRET:  w_sel_cnt = w_instret;
      SYSOP_RDINSTRETH: begin
        w_sel_cnt = w_instret;
        w_sel_hi  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_rd_data = w_sel_hi ? XLEN'(w_sel_cnt >> XLEN) : w_sel_cnt[XLEN-1:0];

  // Result register samples pre-increment counter values on the accepting edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result     <= '0;
      r_result_vld <= 1'b0;
    end else begin
      r_result_vld <= w_accept && !w_is_trap;
      if (w_accept && !w_is_trap) begin
        r_result <= w_rd_data;
      end
    end
  end

  // Trap FSM: state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cause <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && w_is_trap) begin
        r_cause <= (i_sysop == SYSOP_SBREAK);
      end
    end
  end

  // Trap FSM: next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_trap) begin
          w_state_nxt = ST_TRAP_PEND;
        end
      end
      ST_TRAP_PEND: begin
        if (i_trap_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_result       = r_result;
  assign o_result_valid = r_result_vld;
  assign o_trap         = (r_state == ST_TRAP_PEND);
  assign o_busy         = (r_state == ST_TRAP_PEND);
  assign o_trap_cause   = r_cause;

endmodule

// File: tb/tb_system_unit.sv
// Purpose: randomized and directed bench for system_unit against an arithmetic reference model.
// Latency: checks outputs 1 time unit after each rising edge, against the model's post-edge view.
// Backpressure: models acceptance (valid, stall, trap pending) and expects no result for refused requests.

module tb_system_unit;
  import system_unit_pkg::*;

`ifdef SYSTEM_UNIT_INSTRET_EN
  localparam bit INSTRET_EN = 1'b1;
`else
  localparam bit INSTRET_EN = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   vld = 1'b0;
  logic   stall = 1'b0;
  t_sysop op = SYSOP_RDCYCLE;
  logic   retire = 1'b0;
  logic   ack = 1'b0;

  logic [31:0] res0, res1;
  logic [3:0]  res2;
  logic [2:0]  rvld, trap, cause, busy;

  always #5 clk = ~clk;

  // Instance 0: full width, TIME_DIV=4. Instance 1: TIME_DIV=1.
  // Instance 2: scaled 4/8-bit counters so half-carry and wrap are reachable.
  system_unit #(.XLEN(32), .CNT_W(64), .TIME_DIV(4)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_stall(stall), .i_sysop(op),
    .i_retire(retire), .i_trap_ack(ack), .o_result(res0), .o_result_valid(rvld[0]),
    .o_trap(trap[0]), .o_trap_cause(cause[0]), .o_busy(busy[0]));
  system_unit #(.XLEN(32), .CNT_W(64), .TIME_DIV(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_stall(stall), .i_sysop(op),
    .i_retire(retire), .i_trap_ack(ack), .o_result(res1), .o_result_valid(rvld[1]),
    .o_trap(trap[1]), .o_trap_cause(cause[1]), .o_busy(busy[1]));
  system_unit #(.XLEN(4), .CNT_W(8), .TIME_DIV(3)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_stall(stall), .i_sysop(op),
    .i_retire(retire), .i_trap_ack(ack), .o_result(res2), .o_result_valid(rvld[2]),
    .o_trap(trap[2]), .o_trap_cause(cause[2]), .o_busy(busy[2]));

  int td[3] = '{4, 1, 3};
  int cw[3] = '{64, 64, 8};
  int xl[3] = '{32, 32, 4};

  // Reference model: clocks since reset, retires since reset, trap pending flag.
  longint unsigned m_n;
  longint unsigned m_ir;
  bit              m_trap;
  bit              m_cause;
  bit              exp_vld;
  longint unsigned exp_res[3];

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] res_of(int i);
    case (i)
      0:       return {32'd0, res0};
      1:       return {32'd0, res1};
      default: return {60'd0, res2};
    endcase
  endfunction

  // Counter value seen by a read, straight from the arithmetic definitions.
  function automatic longint unsigned model_read(int i, t_sysop o, longint unsigned n,
                                                 longint unsigned ir);
    longint unsigned cnt;
    bit hi;
    hi = 1'b0;
    case (o)
      SYSOP_RDCYCLEH:   begin cnt = n; hi = 1'b1; end
      SYSOP_RDTIME:     cnt = n / longint'(td[i]);
      SYSOP_RDTIMEH:    begin cnt = n / longint'(td[i]); hi = 1'b1; end
      SYSOP_RDINSTRET:  cnt = INSTRET_EN ? ir : 0;
      SYSOP_RDINSTRETH: begin cnt = INSTRET_EN ? ir : 0; hi = 1'b1; end
      default:          cnt = n;
    endcase
    if (cw[i] < 64) cnt = cnt % (64'd1 << cw[i]);
    if (hi) cnt = cnt >> xl[i];
    return cnt & ((64'd1 << xl[i]) - 64'd1);
  endfunction

  task automatic check_outs(string ph);
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("%s i%0d result", ph, i), res_of(i), exp_res[i]);
      chk_eq($sformatf("%s i%0d result_valid", ph, i), 64'(rvld[i]), 64'(exp_vld));
      chk_eq($sformatf("%s i%0d trap", ph, i), 64'(trap[i]), 64'(m_trap));
      chk_eq($sformatf("%s i%0d trap_cause", ph, i), 64'(cause[i]), 64'(m_cause));
      chk_eq($sformatf("%s i%0d busy", ph, i), 64'(busy[i]), 64'(m_trap));
    end
  endtask

  // Apply the current inputs for one clock and check the result.
  task automatic tick(string ph);
    bit acc, trp;
    acc = vld && !stall && !m_trap;
    trp = acc && (op == SYSOP_SCALL || op == SYSOP_SBREAK);
    exp_vld = acc && !trp;
    if (exp_vld) begin
      for (int i = 0; i < 3; i++) exp_res[i] = model_read(i, op, m_n, m_ir);
    end
    if (trp) begin
      m_trap  = 1'b1;
      m_cause = (op == SYSOP_SBREAK);
    end else if (m_trap && ack) begin
      m_trap = 1'b0;
    end
    m_n++;
    if (retire) m_ir++;
    @(posedge clk);
    #1;
    check_outs(ph);
  endtask

  task automatic idle_inputs();
    vld = 1'b0; stall = 1'b0; ack = 1'b0; retire = 1'b0; op = SYSOP_RDCYCLE;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    m_n = 0; m_ir = 0; m_trap = 1'b0; m_cause = 1'b0; exp_vld = 1'b0;
    for (int i = 0; i < 3; i++) exp_res[i] = 0;
    #2;
    check_outs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Counter read after 10 idle clocks.
    do_reset();
    repeat (10) tick("idle10");
    vld = 1'b1; op = SYSOP_RDCYCLE;
    tick("rd10");
    chk_eq("rdcycle10 value", 64'(res0), 64'd10);
    chk_eq("rdcycle10 pulse", 64'(rvld[0]), 64'd1);
    vld = 1'b0;
    tick("rd10 after");
    chk_eq("rdcycle10 single pulse", 64'(rvld[0]), 64'd0);

    // Time prescaler after 17 clocks.
    do_reset();
    repeat (17) tick("idle17");
    vld = 1'b1; op = SYSOP_RDTIME;
    tick("rdtime");
    chk_eq("rdtime div4", 64'(res0), 64'd4);
    chk_eq("rdtime div1", 64'(res1), 64'd17);
    vld = 1'b0;

    // Instret: five retiring clocks, read in the sixth with retire still high.
    do_reset();
    retire = 1'b1;
    repeat (5) tick("retire");
    vld = 1'b1; op = SYSOP_RDINSTRET;
    tick("rdinstret");
    chk_eq("rdinstret", 64'(res0), INSTRET_EN ? 64'd5 : 64'd0);
    idle_inputs();

    // Low-half carry and full wrap on the scaled instance, back-to-back reads.
    do_reset();
    repeat (15) tick("pre carry");
    vld = 1'b1; op = SYSOP_RDCYCLE;
    tick("carry lo");
    chk_eq("carry lo", 64'(res2), 64'hF);
    op = SYSOP_RDCYCLEH;
    tick("carry hi");
    chk_eq("carry hi", 64'(res2), 64'h1);
    chk_eq("carry hi pulse", 64'(rvld[2]), 64'd1);
    vld = 1'b0;
    repeat (238) tick("pre wrap");
    vld = 1'b1; op = SYSOP_RDCYCLEH;
    tick("wrap hi 255");
    chk_eq("wrap hi 255", 64'(res2), 64'hF);
    tick("wrap hi 256");
    chk_eq("wrap hi 256", 64'(res2), 64'h0);
    idle_inputs();

    // SBREAK with ack withheld three cycles; a read is presented throughout.
    vld = 1'b1; op = SYSOP_SBREAK;
    tick("sbreak accept");
    chk_eq("sbreak trap", 64'(trap[0]), 64'd1);
    chk_eq("sbreak cause", 64'(cause[0]), 64'd1);
    op = SYSOP_RDCYCLE;
    repeat (3) tick("sbreak hold");
    chk_eq("sbreak busy", 64'(busy[0]), 64'd1);
    ack = 1'b1;
    tick("sbreak ack");
    chk_eq("after ack trap", 64'(trap[0]), 64'd0);
    ack = 1'b0; vld = 1'b0;
    tick("post ack");

    // SCALL under stall is refused; then a real SCALL and async reset mid-trap.
    vld = 1'b1; stall = 1'b1; op = SYSOP_SCALL;
    tick("scall stalled");
    chk_eq("scall stalled trap", 64'(trap[0]), 64'd0);
    stall = 1'b0;
    tick("scall accept");
    chk_eq("scall cause", 64'(cause[0]), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("async reset trap", 64'(trap[0]), 64'd0);
    chk_eq("async reset busy", 64'(busy[0]), 64'd0);
    do_reset();

    // Random traffic: any opcode (including unlisted ones), stalls, retires, acks.
    for (int k = 0; k < 3000; k++) begin
      vld    = ($urandom_range(0, 9) < 6);
      stall  = ($urandom_range(0, 3) == 0);
      op     = t_sysop'($urandom_range(0, 15));
      retire = $urandom_range(0, 1);
      ack    = ($urandom_range(0, 9) < 3);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/system_unit.md
Name: system_unit

Overview:
- Execute-stage functional unit that consumes the t_sysop command issued by decode when o_exe_unit == SYSTEM_UNIT.
- Maintains the 64-bit cycle, time and instret counters and returns RDCYCLE[H], RDTIME[H] and RDINSTRET[H] results to writeback.
- Converts SCALL/SBREAK into a held trap request with an acknowledge handshake toward the hazard/fetch logic.

Parameters:
- XLEN, 32, result width.
- CNT_W, 64, width of each counter; low half = [XLEN-1:0], high half = [CNT_W-1:XLEN].
- TIME_DIV, 50, clock cycles per time tick; legal range 1..65535.

Ports:
- i_clk  input  1  pipeline clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  system instruction present in execute.
- i_stall  input  1  execute stage stalled; request not accepted.
- i_sysop  input  t_sysop  operation from decode.
- i_retire  input  1  one instruction retired this cycle (writeback).
- i_trap_ack  input  1  trap accepted by fetch/hazard logic.
- o_result  output  XLEN  counter read data.
- o_result_valid  output  1  o_result valid, one-cycle pulse.
- o_trap  output  1  trap request, level, held until acknowledged.
- o_trap_cause  output  1  0 = SCALL, 1 = SBREAK.
- o_busy  output  1  unit cannot accept a new request.

Behaviour:
- Reset (asynchronous on i_rst_n low): all counters 0, prescaler 0, state IDLE.
  - Outputs at reset: o_result = 0, o_result_valid = 0, o_trap = 0, o_trap_cause = 0, o_busy = 0.
  - Reset mid-trap clears the trap immediately, with no ack required.
- Request accepted when i_valid && !i_stall && state == IDLE; otherwise nothing is sampled and the request must be re-presented.
- Cycle counter: +1 every clock after reset; wraps 2^CNT_W-1 -> 0.
- Time counter:
  - Prescaler counts 0..TIME_DIV-1. When the prescaler is at TIME_DIV-1, time increments and the prescaler returns to 0.
  - TIME_DIV == 1: time increments every clock.
  - Wraps like cycle.
- Instret: +1 on each clock with i_retire = 1; wraps.
- Read ops (RDCYCLE, RDCYCLEH, RDTIME, RDTIMEH, RDINSTRET, RDINSTRETH):
  - 1-cycle latency. o_result and o_result_valid register on the edge that accepts the request.
  - Value returned is the counter value before that same edge's increment.
  - o_result holds its last value when o_result_valid = 0.
  - A read accepted in the same cycle as i_retire returns the pre-increment instret.
- Back-to-back reads on consecutive cycles produce consecutive result pulses; no bubbles.
- Trap FSM:
  - IDLE: accepted SCALL/SBREAK -> TRAP_PEND next edge; o_trap = 1 and o_trap_cause latched. o_result_valid stays 0.
  - TRAP_PEND: o_trap = 1 and o_busy = 1; i_valid is ignored.
  - TRAP_PEND with i_trap_ack = 1 -> IDLE next edge. o_trap and o_busy are still 1 during the ack cycle.
  - A request presented during the ack cycle is not accepted.
  - IDLE with i_trap_ack = 1 has no effect.
- All counters keep running in every state, including TRAP_PEND and stall.
- i_sysop values outside the read/trap set, when accepted, behave as RDCYCLE.

Optional Feature:
- Macro: SYSTEM_UNIT_INSTRET_EN.
- Defined: instret counter implemented as above.
- Undefined:
  - No instret register is built and i_retire is unused.
  - RDINSTRET and RDINSTRETH return 0 with normal 1-cycle o_result_valid timing.

Test Plan:
- Reset release, 10 idle clocks, then RDCYCLE accepted in the cycle when the counter holds 10 -> o_result = 10, o_result_valid pulses exactly 1 cycle.
- Force cycle = 0x0000_0000_FFFF_FFFF, RDCYCLE then RDCYCLEH on consecutive cycles -> 0xFFFF_FFFF then 0x0000_0001 (increment carried between the two reads); wrap at 0xFFFF_FFFF_FFFF_FFFF -> 0.
- TIME_DIV = 4, 17 clocks after reset, RDTIME -> 4; same test with TIME_DIV = 1 -> 17.
- i_retire high for 5 clocks, RDINSTRET in the 6th cycle with i_retire = 1 -> 5.
  - Macro undefined: same stimulus returns 0.
- SBREAK accepted, i_trap_ack withheld 3 cycles:
  - o_trap = 1, o_trap_cause = 1, o_busy = 1 for 4 cycles.
  - RDCYCLE presented during that window yields no o_result_valid.
  - After ack, o_trap = 0 next cycle.
- SCALL accepted with i_stall = 1 -> no trap. Assert i_rst_n = 0 while in TRAP_PEND -> o_trap drops immediately, without a clock edge.
